// File: rtl/tick_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider_multi
// Purpose  : Multi-channel programmable tick / clock-enable generator.
//            Each channel counts clk cycles up to its own divisor. It emits a
//            one-cycle tick every div+1 cycles and a wave output, which is a
//            square wave (toggle mode) or a copy of the tick (pulse mode).
//            Divisor and mode are written through a valid/ready port into a
//            per-channel shadow register. The shadow is moved to the active
//            copy only at a period boundary, or while the channel is idle
//            (sync / en low), so the outputs never glitch.
// Ports    : clk        - clock
//            rst        - synchronous reset, active low
//            en[N]      - per-channel run enable
//            sync       - restart every channel in phase
//            cfg_valid  - configuration request
//            cfg_ready  - high when cfg_ch can take a write (no update pending)
//            cfg_ch     - target channel (writes to cfg_ch >= N_CH are dropped)
//            cfg_div    - new divisor (period = cfg_div + 1 cycles)
//            cfg_mode   - 0 = toggle (square wave), 1 = pulse
//            tick[N]    - one-cycle pulse per period (registered)
//            wave[N]    - square wave or pulse (registered)
// Revision : 1.0 - initial release
// ============================================================================
module tick_divider_multi #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 18,
    parameter int DIV_RESET = 200000,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_mode,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  wave
);

    localparam logic [CNT_W-1:0] c_div_rst = CNT_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    // One-hot decode of the config target. An out-of-range channel selects
    // nothing, so it reads as ready and the write falls on the floor.
    logic [N_CH-1:0] w_sel;
    logic [N_CH-1:0] w_pending;

    assign cfg_ready = ~|(w_sel & w_pending);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_div;
            logic [CNT_W-1:0] r_div_sh;
            logic             r_mode;
            logic             r_mode_sh;
            logic             r_pend;
            logic             r_tick;
            logic             r_wave;

            logic             w_term;
            logic             w_apply;
            logic             w_accept;

            assign w_sel[gi]     = (cfg_ch == CH_W'(gi));
            assign w_pending[gi] = r_pend;
            assign tick[gi]      = r_tick;
            assign wave[gi]      = r_wave;

            // >= rather than == lets a divisor shrunk while the channel was
            // idle end the current period at once instead of wrapping.
            assign w_term   = (r_cnt >= r_div);

            // An accept only happens while nothing is pending, so an update
            // accepted on a terminal cycle waits for the next boundary.
            assign w_accept = cfg_valid & w_sel[gi] & ~r_pend;
            assign w_apply  = r_pend & (sync | ~en[gi] | w_term);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt     <= '0;
                    r_div     <= c_div_rst;
                    r_div_sh  <= c_div_rst;
                    r_mode    <= 1'b0;
                    r_mode_sh <= 1'b0;
                    r_pend    <= 1'b0;
                    r_tick    <= 1'b0;
                    r_wave    <= 1'b0;
                end else begin
                    r_tick <= 1'b0;

                    if (sync) begin
                        r_cnt  <= '0;
                        r_wave <= 1'b0;
                    end else if (!en[gi]) begin
                        r_cnt  <= r_cnt;
                    end else if (w_term) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                        r_wave <= r_mode ? 1'b1 : ~r_wave;
                    end else begin
                        r_cnt  <= r_cnt + c_one;
                        if (r_mode) begin
                            r_wave <= 1'b0;
                        end
                    end

                    // Placed after the counter update so a mode change wins
                    // over the terminal wave action; tick is left alone.
                    if (w_apply) begin
                        r_div  <= r_div_sh;
                        r_mode <= r_mode_sh;
                        r_pend <= 1'b0;
                        if (r_mode_sh != r_mode) begin
                            r_wave <= 1'b0;
                        end
                    end

                    if (w_accept) begin
                        r_div_sh  <= cfg_div;
                        r_mode_sh <= cfg_mode;
                        r_pend    <= 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_divider_multi
// Purpose  : Self-checking bench for tick_divider_multi (N_CH=4, DIV_RESET=4).
//            A reference model tracks, per channel, the cycles remaining in
//            the current period and the pending shadow configuration. A
//            negedge monitor compares it with tick, wave and cfg_ready every
//            cycle. The scenario tasks add directed checks with
//            hand-derived expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_divider_multi;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int DR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] en;
    logic          sync;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [CW-1:0] cfg_div;
    logic          cfg_mode;
    logic [NC-1:0] tick;
    logic [NC-1:0] wave;

    int total = 0;
    int bad   = 0;

    tick_divider_multi #(
        .N_CH      (NC),
        .CNT_W     (CW),
        .DIV_RESET (DR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .tick      (tick),
        .wave      (wave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: m_rem = cycles still to count before the period ends
    // (<= 0 means the next enabled cycle is the terminal one).
    // ------------------------------------------------------------------
    int m_rem [NC];
    int m_div [NC];
    int m_dsh [NC];
    bit m_mode[NC];
    bit m_msh [NC];
    bit m_pend[NC];
    bit m_tick[NC];
    bit m_wave[NC];

    task automatic model_step();
        for (int c = 0; c < NC; c++) begin
            bit acc;
            bit term;
            bit app;
            bit nm;
            int nd;
            if (!rst) begin
                m_rem[c]  = DR;
                m_div[c]  = DR;
                m_mode[c] = 1'b0;
                m_pend[c] = 1'b0;
                m_tick[c] = 1'b0;
                m_wave[c] = 1'b0;
            end else begin
                acc  = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
                term = (m_rem[c] <= 0);
                app  = m_pend[c] && (sync || !en[c] || term);
                nd   = app ? m_dsh[c] : m_div[c];
                nm   = app ? m_msh[c] : m_mode[c];
                if (sync) begin
                    m_tick[c] = 1'b0;
                    m_wave[c] = 1'b0;
                    m_rem[c]  = nd;
                end else if (!en[c]) begin
                    m_tick[c] = 1'b0;
                    m_rem[c]  = m_rem[c] + nd - m_div[c];
                end else if (term) begin
                    m_tick[c] = 1'b1;
                    m_wave[c] = m_mode[c] ? 1'b1 : !m_wave[c];
                    m_rem[c]  = nd;
                end else begin
                    m_tick[c] = 1'b0;
                    m_rem[c]  = m_rem[c] - 1;
                    if (m_mode[c]) m_wave[c] = 1'b0;
                end
                if (app && (nm != m_mode[c])) m_wave[c] = 1'b0;
                m_div[c]  = nd;
                m_mode[c] = nm;
                if (app) m_pend[c] = 1'b0;
                if (acc) begin
                    m_dsh[c]  = int'(cfg_div);
                    m_msh[c]  = cfg_mode;
                    m_pend[c] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Cycle-by-cycle scoreboard against the model.
    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            total++;
            if (tick[c] !== m_tick[c]) begin
                bad++;
                $display("FAIL mon_tick ch%0d t=%0t got=%b exp=%b", c, $time, tick[c], m_tick[c]);
            end
            total++;
            if (wave[c] !== m_wave[c]) begin
                bad++;
                $display("FAIL mon_wave ch%0d t=%0t got=%b exp=%b", c, $time, wave[c], m_wave[c]);
            end
        end
        total++;
        if (cfg_ready !== !m_pend[cfg_ch]) begin
            bad++;
            $display("FAIL mon_ready ch%0d t=%0t got=%b exp=%b", cfg_ch, $time, cfg_ready, !m_pend[cfg_ch]);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 2'd0; cfg_div = '0; cfg_mode = 1'b0;
        step(3);
        total++;
        if (tick !== 4'h0 || wave !== 4'h0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got tick=%h wave=%h ready=%b exp 0 0 1", tick, wave, cfg_ready);
        end
        rst = 1'b1; en = 4'hF;
        for (int i = 1; i <= 25; i++) begin
            logic [NC-1:0] et;
            logic [NC-1:0] ew;
            step();
            et = (i % 5 == 0) ? 4'hF : 4'h0;
            ew = (((i / 5) % 2) == 1) ? 4'hF : 4'h0;
            total++;
            if (tick !== et || wave !== ew) begin
                bad++;
                $display("FAIL reset_period i=%0d got tick=%h wave=%h exp tick=%h wave=%h", i, tick, wave, et, ew);
            end
        end
    endtask

    task automatic test_cfg_pulse();
        int k;
        k = 0;
        while ((m_div[1] - m_rem[1]) != 1 && k < 10) begin step(); k++; end
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; cfg_mode = 1'b1;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL cfg_ready_before got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++; $display("FAIL cfg_ready_pending got=%b exp=0", cfg_ready);
        end
        k = 0;
        do begin step(); k++; end while (tick[1] !== 1'b1 && k < 10);
        total++;
        if (k != 3 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL cfg_apply got cycles=%0d ready=%b exp cycles=3 ready=1", k, cfg_ready);
        end
        for (int j = 1; j <= 6; j++) begin
            logic e;
            step();
            e = (j % 3 == 0);
            total++;
            if (tick[1] !== e || wave[1] !== e) begin
                bad++; $display("FAIL pulse_period j=%0d got tick=%b wave=%b exp=%b", j, tick[1], wave[1], e);
            end
        end
    endtask

    task automatic test_pending_block();
        int k;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5; cfg_mode = 1'b0;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL pend_first_ready got=%b exp=1", cfg_ready);
        end
        step();
        cfg_div = 8'd1; cfg_mode = 1'b1;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++; $display("FAIL pend_second_ready got=%b exp=0", cfg_ready);
        end
        step();
        cfg_ch = 2'd2; cfg_div = 8'd4; cfg_mode = 1'b0;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++; $display("FAIL pend_other_ch_ready got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        total++;
        if (tick[1] !== 1'b1 || wave[1] !== 1'b0) begin
            bad++; $display("FAIL pend_apply_tick got tick=%b wave=%b exp tick=1 wave=0", tick[1], wave[1]);
        end
        k = 0;
        do begin step(); k++; end while (tick[1] !== 1'b1 && k < 12);
        total++;
        if (k != 6) begin
            bad++; $display("FAIL pend_new_period got=%0d exp=6", k);
        end
    endtask

    task automatic test_en_hold();
        int  k;
        bit  hold_w;
        k = 0;
        while ((m_div[0] - m_rem[0]) != 2 && k < 10) begin step(); k++; end
        hold_w = m_wave[0];
        en = 4'b1110;
        for (int i = 1; i <= 7; i++) begin
            step();
            total++;
            if (tick[0] !== 1'b0 || wave[0] !== hold_w) begin
                bad++; $display("FAIL en_hold i=%0d got tick=%b wave=%b exp tick=0 wave=%b", i, tick[0], wave[0], hold_w);
            end
        end
        en = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (tick[0] !== (i == 3)) begin
                bad++; $display("FAIL en_resume i=%0d got=%b exp=%b", i, tick[0], (i == 3));
            end
        end
    endtask

    task automatic test_sync();
        int k;
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        k = 0;
        while (m_pend[3] && k < 12) begin step(); k++; end
        total++;
        if (k >= 12) begin
            bad++; $display("FAIL sync_cfg_timeout got=%0d exp<12", k);
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        total++;
        if (tick !== 4'h0 || wave !== 4'h0) begin
            bad++; $display("FAIL sync_clear got tick=%h wave=%h exp 0 0", tick, wave);
        end
        for (int i = 1; i <= 6; i++) begin
            logic [NC-1:0] et;
            step();
            et = {1'b1, (i == 5), (i == 6), (i == 5)};
            total++;
            if (tick !== et || wave[3] !== logic'(i % 2)) begin
                bad++; $display("FAIL sync_align i=%0d got tick=%h wave3=%b exp tick=%h wave3=%0d", i, tick, wave[3], et, i % 2);
            end
        end
    endtask

    task automatic test_reset_pending();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5; cfg_mode = 1'b1;
        step();
        cfg_valid = 1'b0;
        total++;
        if (cfg_ready !== 1'b0 || tick[3] !== 1'b1) begin
            bad++; $display("FAIL rstp_accept got ready=%b tick3=%b exp 0 1", cfg_ready, tick[3]);
        end
        rst = 1'b0;
        step();
        total++;
        if (tick !== 4'h0 || wave !== 4'h0 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL rstp_clear got tick=%h wave=%h ready=%b exp 0 0 1", tick, wave, cfg_ready);
        end
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            logic [NC-1:0] et;
            step();
            et = (i % 5 == 0) ? 4'hF : 4'h0;
            total++;
            if (tick !== et) begin
                bad++; $display("FAIL rstp_div i=%0d got=%h exp=%h", i, tick, et);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) != 0);
            sync      = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NC; c++) en[c] = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = 8'($urandom_range(0, 9));
            cfg_mode  = 1'($urandom_range(0, 1));
            step();
            for (int c = 0; c < NC; c++) begin
                total++;
                if (tick[c] !== m_tick[c] || wave[c] !== m_wave[c]) begin
                    bad++;
                    $display("FAIL random i=%0d ch%0d got tick=%b wave=%b exp tick=%b wave=%b",
                             i, c, tick[c], wave[c], m_tick[c], m_wave[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_pulse();
        test_pending_block();
        test_en_hold();
        test_sync();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog t=%0t exp finish earlier", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_divider_multi.md
# tick_divider_multi

Multi-channel programmable tick/clock-enable generator: each channel counts `clk` cycles against its own divisor and emits a one-cycle `tick` plus a `wave` output (square wave or pulse, per channel). Divisor and mode are reprogrammed at run time through a valid/ready port. Updates are shadowed and applied only at a period boundary, so outputs never glitch. The block sits at the top of the design and feeds display scan, debounce sampling and slow LED/blink logic from a single instance.

## Interface
Parameters:
- `N_CH`, 4, number of independent channels (≥1)
- `CNT_W`, 18, counter/divisor width in bits
- `DIV_RESET`, 200000, divisor loaded into every channel at reset (must fit in `CNT_W`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `en`  in  N_CH  per-channel run enable
- `sync`  in  1  phase-align: restart all channels together
- `cfg_valid`  in  1  configuration request
- `cfg_ready`  out  1  configuration accepted when high with `cfg_valid`
- `cfg_ch`  in  max(1,$clog2(N_CH))  target channel
- `cfg_div`  in  CNT_W  new divisor; period = `cfg_div`+1 cycles
- `cfg_mode`  in  1  0 = toggle (square wave), 1 = pulse
- `tick`  out  N_CH  one-cycle pulse per period, every mode
- `wave`  out  N_CH  toggle mode: flips once per period; pulse mode: equals `tick`

## Operation
- Per-channel state: `cnt`, active `div`/`mode`, shadow `div_sh`/`mode_sh`, `pending` flag, registered `tick` and `wave`.
- Reset (`rst`=0 at a `clk` edge): `cnt`=0, `div`=`DIV_RESET`, `mode`=0, `pending`=0, `tick`=0, `wave`=0, for all channels.
- Per-channel priority each cycle: `rst` > `sync` > `en`=0 > terminal > increment.
  - `sync`=1: `cnt`<=0, `tick`<=0, `wave`<=0; a pending update is applied now.
  - `en[i]`=0: `cnt` and `wave` hold, `tick`<=0; a pending update is applied now.
  - Terminal (`cnt` >= `div`): `cnt`<=0, `tick`<=1. Toggle mode: `wave`<=~`wave`. Pulse mode: `wave`<=1. A pending update is applied now.
  - Otherwise: `cnt`<=`cnt`+1, `tick`<=0. In pulse mode `wave`<=0; in toggle mode `wave` holds.
- Applying an update means `div`<=`div_sh`, `mode`<=`mode_sh`, `pending`<=0. If the mode changes, `wave`<=0 in that cycle. This overrides the terminal `wave` action but not `tick`.
- `div`=0 gives a tick every cycle; in toggle mode `wave` then flips every cycle.
- Config handshake:
  - `cfg_ready` = ~`pending[cfg_ch]` (combinational).
  - Accept = `cfg_valid` & `cfg_ready`, which loads `div_sh`/`mode_sh` and sets `pending`.
  - `cfg_ch` ≥ `N_CH`: `cfg_ready`=1 and the write is dropped.
- An accept and a terminal on the same channel in the same cycle: the new value is not applied in that cycle. It takes effect at the next terminal, or at the next `sync`/`en`=0 cycle.
- Counter arithmetic is unsigned `CNT_W` bits. Because of the `>=` compare, a count can never run past `div`.

## Timing
- `tick`/`wave` are registered. A terminal detected in cycle t appears on the outputs in cycle t+1.
- Period is `div`+1 cycles: ticks are exactly `div`+1 cycles apart while enabled.
- After reset or `sync` is released with `en`=1, the first `tick` is high `div`+1 cycles later.
- Latency of a configuration update is at most one full old period after the accept.
- `cfg_ready` drops in the cycle after an accept and rises in the cycle after the update is applied.
- Reset in the middle of a period or with an update pending: everything returns to reset values and the pending update is lost.
- Channels are fully independent, apart from the shared `sync`, `rst` and config port.

## Test plan
- Reset, `en`=all 1, `N_CH`=4, `DIV_RESET`=4 -> on every channel `tick` is high every 5 cycles, first at cycle 5 after reset release, and `wave` toggles with period 10.
- Program ch1 `div`=2, mode pulse, while ch1 is at `cnt`=1 -> `cfg_ready` goes low. The old period finishes, then `tick`/`wave` pulse every 3 cycles and `cfg_ready` returns high.
- Second `cfg_valid` to ch1 while pending -> `cfg_ready`=0 and the write is not accepted. A write to ch2 in the same state is accepted.
- Deassert `en[0]` for 7 cycles at `cnt`=2 -> no ticks and `wave` holds. After re-enable, the first tick arrives 3 cycles later (`div`=4).
- Channels at different phases, pulse `sync` -> all channels' ticks coincide `div`+1 cycles later; `div`=0 gives a tick every cycle.
- Accept and terminal in the same cycle on ch3, then `rst`=0 in the next cycle -> all outputs are 0, `div`=`DIV_RESET`, and `pending`=0.
